// File: rtl/ctrl_fsm.sv
// ctrl_fsm: opcode decoder plus multi-cycle sequencer for the core.
//
// Decodes the instruction opcode into datapath control strobes. Adds three
// sequencing behaviours on top of the decode:
//   - mult/div take MULDIV_CYCLES cycles in total.
//   - in/out wait for a fresh push-button press.
//   - halt stops the core until reset.
//
// Parameters:
//   OPCODE_W      opcode width; real opcodes use the low 6 bits
//   ALU_W         alu_code width; "no-op" is all ones
//   MULDIV_CYCLES total cycles for mult/div (minimum 1)
//
// Ports:
//   clock                   rising-edge clock
//   reset                   synchronous, active-high
//   Button                  asynchronous push-button (I/O acknowledge)
//   Valid, Opcode           new instruction presented this cycle
//   alu_code                ALU operation
//   ALU, branch, Halt, Im, In, Jal, Jr, Jump, Write, WriteMem, useStk,
//   type_r                  datapath controls
//   Stall                   hold PC/IR; the instruction has not committed
module ctrl_fsm #(
  parameter int OPCODE_W      = 6,
  parameter int ALU_W         = 5,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Button,
  input  logic                Valid,
  input  logic [OPCODE_W-1:0] Opcode,
  output logic [ALU_W-1:0]    alu_code,
  output logic                ALU,
  output logic                branch,
  output logic                Halt,
  output logic                Im,
  output logic                In,
  output logic                Jal,
  output logic                Jr,
  output logic                Jump,
  output logic                Write,
  output logic                WriteMem,
  output logic                useStk,
  output logic                type_r,
  output logic                Stall
);

  // The counter only ever holds MULDIV_CYCLES-2 down to 0.
  localparam int CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
      CNT_W'((MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0);

  typedef logic [OPCODE_W-1:0] op_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_MULDIV = 2'd1,
    S_IOWAIT = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] code;
    logic alu;
    logic branch;
    logic halt;
    logic im;
    logic in_en;
    logic jal;
    logic jr;
    logic jump;
    logic write;
    logic wmem;
    logic stk;
    logic type_r;
  } ctl_t;

  function automatic ctl_t ctl_idle();
    ctl_t c;
    c      = '0;
    c.code = '1;
    return c;
  endfunction

  // Opcodes are compared at full width, so any set upper bit falls to default.
  function automatic ctl_t decode(input op_t op);
    ctl_t c;
    c = ctl_idle();
    case (op)
      op_t'(6'o01): c.halt = 1'b1;
      op_t'(6'o02): begin c.alu = 1'b1; c.write = 1'b1; c.type_r = 1'b1; c.code = ALU_W'(3'd0); end
      op_t'(6'o03): begin c.alu = 1'b1; c.write = 1'b1; c.type_r = 1'b1; c.code = ALU_W'(3'd1); end
      op_t'(6'o04): begin c.alu = 1'b1; c.write = 1'b1; c.type_r = 1'b1; c.code = ALU_W'(3'd3); end
      op_t'(6'o05): begin c.alu = 1'b1; c.write = 1'b1; c.type_r = 1'b1; c.code = ALU_W'(3'd4); end
      op_t'(6'o22): begin c.alu = 1'b1; c.write = 1'b1; c.type_r = 1'b1; c.code = ALU_W'(3'd6); end
      op_t'(6'o23): begin c.alu = 1'b1; c.write = 1'b1; c.type_r = 1'b1; c.code = ALU_W'(3'd7); end
      op_t'(6'o24): begin c.alu = 1'b1; c.im = 1'b1; c.write = 1'b1; c.code = ALU_W'(3'd0); end
      op_t'(6'o25): begin c.alu = 1'b1; c.im = 1'b1; c.write = 1'b1; c.code = ALU_W'(3'd1); end
      op_t'(6'o26): begin c.alu = 1'b1; c.im = 1'b1; c.write = 1'b1; c.code = ALU_W'(3'd5); end
      op_t'(6'o06): begin c.alu = 1'b1; c.write = 1'b1; c.code = ALU_W'(3'd2); end
      op_t'(6'o20): begin c.branch = 1'b1; c.code = ALU_W'(3'd1); end
      op_t'(6'o21): c.code = ALU_W'(3'd1);
      op_t'(6'o07): begin c.im = 1'b1; c.write = 1'b1; c.code = ALU_W'(3'd0); end
      op_t'(6'o10): begin c.im = 1'b1; c.wmem = 1'b1; c.code = ALU_W'(3'd0); end
      op_t'(6'o11): begin c.im = 1'b1; c.wmem = 1'b1; c.stk = 1'b1; end
      op_t'(6'o12): begin c.im = 1'b1; c.write = 1'b1; c.stk = 1'b1; end
      op_t'(6'o13): begin c.alu = 1'b1; c.im = 1'b1; c.in_en = 1'b1; c.write = 1'b1; c.code = ALU_W'(3'd5); end
      op_t'(6'o14): c.code = '1;
      op_t'(6'o15): c.jr = 1'b1;
      op_t'(6'o16): c.jump = 1'b1;
      op_t'(6'o17): begin c.jal = 1'b1; c.jump = 1'b1; end
      default:      c.code = '1;
    endcase
    return c;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  op_t              op_q, op_nxt_s;
  logic             sync1_r, sync2_r, sync2_d_r, btn_rise_r;
  ctl_t             ctl_s;
  logic             stall_s, hold_halt_s;

  // Button synchroniser and registered rising-edge detector.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      sync2_d_r  <= 1'b0;
      btn_rise_r <= 1'b0;
    end else begin
      sync1_r    <= Button;
      sync2_r    <= sync1_r;
      sync2_d_r  <= sync2_r;
      btn_rise_r <= sync2_r & ~sync2_d_r;
    end
  end

  // FSM state, mult/div counter and latched opcode.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_RUN;
      cnt_r   <= '0;
      op_q    <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      op_q    <= op_nxt_s;
    end
  end

  // Next-state logic and pre-commit control selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    op_nxt_s    = op_q;
    ctl_s       = ctl_idle();
    stall_s     = 1'b0;
    hold_halt_s = 1'b0;
    if (reset) begin
      state_nxt_s = S_RUN;
    end else begin
      case (state_r)
        S_RUN: begin
          if (Valid) begin
            ctl_s = decode(Opcode);
            if (((Opcode == op_t'(6'o04)) || (Opcode == op_t'(6'o05))) && (MULDIV_CYCLES > 1)) begin
              op_nxt_s    = Opcode;
              cnt_nxt_s   = CNT_LOAD;
              stall_s     = 1'b1;
              state_nxt_s = S_MULDIV;
            end else if ((Opcode == op_t'(6'o13)) || (Opcode == op_t'(6'o14))) begin
              op_nxt_s    = Opcode;
              stall_s     = 1'b1;
              hold_halt_s = 1'b1;
              state_nxt_s = S_IOWAIT;
            end else if (Opcode == op_t'(6'o01)) begin
              stall_s     = 1'b1;
              state_nxt_s = S_HALTED;
            end else begin
              state_nxt_s = S_RUN;
            end
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_MULDIV: begin
          ctl_s = decode(op_q);
          if (cnt_r != '0) begin
            stall_s   = 1'b1;
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_IOWAIT: begin
          ctl_s = decode(op_q);
          if (btn_rise_r) begin
            state_nxt_s = S_RUN;
          end else begin
            stall_s     = 1'b1;
            hold_halt_s = 1'b1;
          end
        end
        S_HALTED: begin
          stall_s     = 1'b1;
          hold_halt_s = 1'b1;
        end
        default: state_nxt_s = S_RUN;
      endcase
    end
  end

  // Commit-only strobes are masked whenever the instruction is still stalled.
  assign alu_code = ctl_s.code;
  assign ALU      = ctl_s.alu;
  assign Im       = ctl_s.im;
  assign useStk   = ctl_s.stk;
  assign type_r   = ctl_s.type_r;
  assign Halt     = ctl_s.halt | hold_halt_s;
  assign Stall    = stall_s;
  assign Write    = ctl_s.write  & ~stall_s;
  assign WriteMem = ctl_s.wmem   & ~stall_s;
  assign Jump     = ctl_s.jump   & ~stall_s;
  assign Jr       = ctl_s.jr     & ~stall_s;
  assign Jal      = ctl_s.jal    & ~stall_s;
  assign branch   = ctl_s.branch & ~stall_s;
  assign In       = ctl_s.in_en  & ~stall_s;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: default instance (OPCODE_W=6, MULDIV_CYCLES=4) and a
// second instance (OPCODE_W=8, MULDIV_CYCLES=1). Each cycle's expected output
// vector is queued when stimulus is applied and popped when the outputs are
// sampled, 3 time units after the falling edge.
module tb_ctrl_fsm;

  localparam logic [12:0] F_STALL = 13'h0001;
  localparam logic [12:0] F_TYPER = 13'h0002;
  localparam logic [12:0] F_STK   = 13'h0004;
  localparam logic [12:0] F_WMEM  = 13'h0008;
  localparam logic [12:0] F_WRITE = 13'h0010;
  localparam logic [12:0] F_JUMP  = 13'h0020;
  localparam logic [12:0] F_JR    = 13'h0040;
  localparam logic [12:0] F_JAL   = 13'h0080;
  localparam logic [12:0] F_IN    = 13'h0100;
  localparam logic [12:0] F_IM    = 13'h0200;
  localparam logic [12:0] F_HALT  = 13'h0400;
  localparam logic [12:0] F_BR    = 13'h0800;
  localparam logic [12:0] F_ALU   = 13'h1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       Button = 1'b0;
  logic       Valid = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       Valid1 = 1'b0;
  logic [7:0] Opcode1 = 8'd0;

  logic [4:0] alu0, alu1;
  logic a0, br0, h0, im0, in0, jal0, jr0, j0, w0, wm0, st0, tr0, s0;
  logic a1, br1, h1, im1, in1, jal1, jr1, j1, w1, wm1, st1, tr1, s1;
  logic [17:0] obs0, obs1;

  assign obs0 = {alu0, a0, br0, h0, im0, in0, jal0, jr0, j0, w0, wm0, st0, tr0, s0};
  assign obs1 = {alu1, a1, br1, h1, im1, in1, jal1, jr1, j1, w1, wm1, st1, tr1, s1};

  ctrl_fsm #(.OPCODE_W(6), .ALU_W(5), .MULDIV_CYCLES(4)) dut0 (
    .clock(clock), .reset(reset), .Button(Button), .Valid(Valid), .Opcode(Opcode),
    .alu_code(alu0), .ALU(a0), .branch(br0), .Halt(h0), .Im(im0), .In(in0),
    .Jal(jal0), .Jr(jr0), .Jump(j0), .Write(w0), .WriteMem(wm0), .useStk(st0),
    .type_r(tr0), .Stall(s0)
  );

  ctrl_fsm #(.OPCODE_W(8), .ALU_W(5), .MULDIV_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .Button(Button), .Valid(Valid1), .Opcode(Opcode1),
    .alu_code(alu1), .ALU(a1), .branch(br1), .Halt(h1), .Im(im1), .In(in1),
    .Jal(jal1), .Jr(jr1), .Jump(j1), .Write(w1), .WriteMem(wm1), .useStk(st1),
    .type_r(tr1), .Stall(s1)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        r;
    logic        v;
    logic [7:0]  op;
    logic        b;
    logic [17:0] e;
  } stim_t;

  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [17:0] ev(input logic [4:0] code, input logic [12:0] f);
    return {code, f};
  endfunction

  function automatic stim_t S(input logic r, input logic v, input logic [7:0] op,
                              input logic b, input logic [17:0] e);
    stim_t s;
    s.r = r; s.v = v; s.op = op; s.b = b; s.e = e;
    return s;
  endfunction

  // Reference decode of a committing single-cycle opcode.
  function automatic logic [17:0] ref_dec(input logic [5:0] op);
    case (op)
      6'o02: return ev(5'd0, F_ALU | F_WRITE | F_TYPER);
      6'o03: return ev(5'd1, F_ALU | F_WRITE | F_TYPER);
      6'o22: return ev(5'd6, F_ALU | F_WRITE | F_TYPER);
      6'o23: return ev(5'd7, F_ALU | F_WRITE | F_TYPER);
      6'o24: return ev(5'd0, F_ALU | F_IM | F_WRITE);
      6'o25: return ev(5'd1, F_ALU | F_IM | F_WRITE);
      6'o26: return ev(5'd5, F_ALU | F_IM | F_WRITE);
      6'o06: return ev(5'd2, F_ALU | F_WRITE);
      6'o20: return ev(5'd1, F_BR);
      6'o21: return ev(5'd1, 13'h0000);
      6'o07: return ev(5'd0, F_IM | F_WRITE);
      6'o10: return ev(5'd0, F_IM | F_WMEM);
      6'o11: return ev(5'h1f, F_IM | F_WMEM | F_STK);
      6'o12: return ev(5'h1f, F_IM | F_WRITE | F_STK);
      6'o15: return ev(5'h1f, F_JR);
      6'o16: return ev(5'h1f, F_JUMP);
      6'o17: return ev(5'h1f, F_JAL | F_JUMP);
      default: return ev(5'h1f, 13'h0000);
    endcase
  endfunction

  // Drive one cycle's inputs at the falling edge and queue its expectation.
  task automatic apply(input stim_t s, input bit to1);
    @(negedge clock);
    reset  = s.r;
    Button = s.b;
    if (to1) begin
      Valid1 = s.v; Opcode1 = s.op; Valid = 1'b0;
    end else begin
      Valid = s.v; Opcode = s.op[5:0]; Valid1 = 1'b0;
    end
    exp_q.push_back(s.e);
    #3;
  endtask

  localparam logic [17:0] IDLE = {5'h1f, 13'h0000};

  task automatic test_reset();
    stim_t st[$];
    logic [17:0] e;
    st.push_back(S(1'b1, 1'b1, 8'o02, 1'b0, IDLE));
    st.push_back(S(1'b1, 1'b1, 8'o02, 1'b0, IDLE));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b0, ev(5'd0, F_ALU | F_WRITE | F_TYPER)));
    st.push_back(S(1'b0, 1'b0, 8'o02, 1'b0, IDLE));
    foreach (st[i]) begin
      apply(st[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL reset[%0d]: got %h, expected %h", i, obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_decode();
    logic [5:0] ops[20] = '{6'o02, 6'o03, 6'o22, 6'o23, 6'o24, 6'o25, 6'o26, 6'o06,
                            6'o20, 6'o21, 6'o07, 6'o10, 6'o11, 6'o12, 6'o15, 6'o16,
                            6'o17, 6'o30, 6'o00, 6'o77};
    logic [17:0] e;
    foreach (ops[i]) begin
      apply(S(1'b0, 1'b1, {2'b00, ops[i]}, 1'b0, ref_dec(ops[i])), 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL decode[op=%o]: got %h, expected %h", ops[i], obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_mult();
    stim_t st[$];
    logic [17:0] e;
    logic [17:0] busy = ev(5'd3, F_ALU | F_TYPER | F_STALL);
    st.push_back(S(1'b0, 1'b1, 8'o04, 1'b0, busy));
    st.push_back(S(1'b0, 1'b1, 8'o03, 1'b0, busy));
    st.push_back(S(1'b0, 1'b1, 8'o03, 1'b0, busy));
    st.push_back(S(1'b0, 1'b1, 8'o03, 1'b0, ev(5'd3, F_ALU | F_TYPER | F_WRITE)));
    st.push_back(S(1'b0, 1'b0, 8'o03, 1'b0, IDLE));
    foreach (st[i]) begin
      apply(st[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL mult[%0d]: got %h, expected %h", i, obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [17:0] e;
    logic [17:0] busy = ev(5'd4, F_ALU | F_TYPER | F_STALL);
    st.push_back(S(1'b0, 1'b1, 8'o05, 1'b0, busy));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b0, busy));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b0, busy));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b0, ev(5'd4, F_ALU | F_TYPER | F_WRITE)));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b0, ev(5'd0, F_ALU | F_TYPER | F_WRITE)));
    st.push_back(S(1'b0, 1'b1, 8'o03, 1'b0, ev(5'd1, F_ALU | F_TYPER | F_WRITE)));
    st.push_back(S(1'b0, 1'b0, 8'o03, 1'b0, IDLE));
    foreach (st[i]) begin
      apply(st[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL back_to_back[%0d]: got %h, expected %h", i, obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_in_held_button();
    stim_t st[$];
    logic [17:0] e;
    logic [17:0] wt = ev(5'd5, F_ALU | F_IM | F_HALT | F_STALL);
    for (int k = 0; k < 4; k++) st.push_back(S(1'b0, 1'b0, 8'o00, 1'b1, IDLE));
    st.push_back(S(1'b0, 1'b1, 8'o13, 1'b1, wt));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b1, wt));
    for (int k = 0; k < 3; k++) st.push_back(S(1'b0, 1'b0, 8'o00, 1'b1, wt));
    for (int k = 0; k < 3; k++) st.push_back(S(1'b0, 1'b1, 8'o17, 1'b0, wt));
    for (int k = 0; k < 3; k++) st.push_back(S(1'b0, 1'b0, 8'o00, 1'b1, wt));
    st.push_back(S(1'b0, 1'b0, 8'o00, 1'b1, ev(5'd5, F_ALU | F_IM | F_IN | F_WRITE)));
    st.push_back(S(1'b0, 1'b0, 8'o00, 1'b1, IDLE));
    foreach (st[i]) begin
      apply(st[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL in_wait[%0d]: got %h, expected %h", i, obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_out_short_release();
    stim_t st[$];
    logic [17:0] e;
    logic [17:0] wt = ev(5'h1f, F_HALT | F_STALL);
    st.push_back(S(1'b0, 1'b1, 8'o14, 1'b1, wt));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b1, wt));
    st.push_back(S(1'b0, 1'b0, 8'o00, 1'b0, wt));
    for (int k = 0; k < 3; k++) st.push_back(S(1'b0, 1'b0, 8'o00, 1'b1, wt));
    st.push_back(S(1'b0, 1'b1, 8'o00, 1'b1, IDLE));
    st.push_back(S(1'b0, 1'b1, 8'o16, 1'b1, ev(5'h1f, F_JUMP)));
    foreach (st[i]) begin
      apply(st[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL out_wait[%0d]: got %h, expected %h", i, obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    stim_t st[$];
    logic [17:0] e;
    logic [17:0] hl = ev(5'h1f, F_HALT | F_STALL);
    st.push_back(S(1'b0, 1'b1, 8'o01, 1'b0, hl));
    for (int k = 0; k < 6; k++)
      st.push_back(S(1'b0, k[0], (k[0] ? 8'o02 : 8'o13), k[0], hl));
    st.push_back(S(1'b1, 1'b1, 8'o02, 1'b0, IDLE));
    st.push_back(S(1'b0, 1'b0, 8'o02, 1'b0, IDLE));
    st.push_back(S(1'b0, 1'b1, 8'o02, 1'b0, ev(5'd0, F_ALU | F_WRITE | F_TYPER)));
    foreach (st[i]) begin
      apply(st[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL halt[%0d]: got %h, expected %h", i, obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_muldiv();
    stim_t st[$];
    logic [17:0] e;
    logic [17:0] busy = ev(5'd3, F_ALU | F_TYPER | F_STALL);
    st.push_back(S(1'b0, 1'b1, 8'o04, 1'b0, busy));
    st.push_back(S(1'b0, 1'b1, 8'o04, 1'b0, busy));
    st.push_back(S(1'b1, 1'b1, 8'o04, 1'b0, IDLE));
    for (int k = 0; k < 3; k++) st.push_back(S(1'b0, 1'b0, 8'o04, 1'b0, IDLE));
    foreach (st[i]) begin
      apply(st[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs0 !== e) $display("FAIL reset_mid[%0d]: got %h, expected %h", i, obs0, e);
      else n_pass++;
    end
  endtask

  task automatic test_wide_single_cycle_muldiv();
    stim_t st[$];
    logic [17:0] e;
    st.push_back(S(1'b0, 1'b1, 8'h44, 1'b0, IDLE));
    st.push_back(S(1'b0, 1'b1, 8'h04, 1'b0, ev(5'd3, F_ALU | F_WRITE | F_TYPER)));
    st.push_back(S(1'b0, 1'b1, 8'h05, 1'b0, ev(5'd4, F_ALU | F_WRITE | F_TYPER)));
    st.push_back(S(1'b0, 1'b1, 8'h84, 1'b0, IDLE));
    st.push_back(S(1'b0, 1'b1, 8'h02, 1'b0, ev(5'd0, F_ALU | F_WRITE | F_TYPER)));
    st.push_back(S(1'b0, 1'b0, 8'h02, 1'b0, IDLE));
    foreach (st[i]) begin
      apply(st[i], 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs1 !== e) $display("FAIL wide_md1[%0d]: got %h, expected %h", i, obs1, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_back_to_back();
    test_in_held_button();
    test_out_short_release();
    test_halt();
    test_reset_mid_muldiv();
    test_wide_single_cycle_muldiv();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
